// File: rtl/mod10_ctrl_pkg.sv
// Shared types and constants for the mod-10 count controller.
// Holds the controller FSM state encoding and the mod-10 step helper.
package mod10_ctrl_pkg;

  localparam int                 DIGIT_W   = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_e;

  function automatic logic [DIGIT_W-1:0] digit_step(input logic [DIGIT_W-1:0] d,
                                                    input logic               up);
    if (up) return (d == DIGIT_MAX) ? '0 : d + 1'b1;
    else    return (d == '0) ? DIGIT_MAX : d - 1'b1;
  endfunction

endpackage

// File: rtl/mod10_digit.sv
// Mod-10 digit register with synchronous clear, load and single-step control.
// wrap is registered so it rises together with the wrapped digit value.
module mod10_digit
  import mod10_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               step_en,
  input  logic               step_up,
  output logic [DIGIT_W-1:0] digit,
  output logic               wrap
);

  logic [DIGIT_W-1:0] digit_d, digit_q;
  logic               wrap_d, wrap_q;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    digit_d = digit_q;
    wrap_d  = 1'b0;
    if (load_en) begin
      digit_d = load_val;
    end else if (step_en) begin
      digit_d = digit_step(digit_q, step_up);
      wrap_d  = step_up ? (digit_q == DIGIT_MAX) : (digit_q == '0);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      digit_q <= digit_d;
      wrap_q  <= wrap_d;
    end
  end

  assign digit = digit_q;
  assign wrap  = wrap_q;

endmodule

// File: rtl/mod10_count_ctrl.sv
// Command-driven mod-10 counter: load a digit or run N up/down steps, then pulse done.
// Define COUNT_CTRL_PAUSE_EN to add a pause input that stalls stepping while in RUN.
module mod10_count_ctrl
  import mod10_ctrl_pkg::*;
#(
  parameter int STEP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef COUNT_CTRL_PAUSE_EN
  input  logic               pause,
`endif
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_load,
  input  logic               cmd_dir,
  input  logic [STEP_W-1:0]  cmd_steps,
  input  logic [DIGIT_W-1:0] cmd_value,
  output logic [DIGIT_W-1:0] digit,
  output logic               busy,
  output logic               wrap,
  output logic               done,
  output logic               err
);

  ctrl_state_e       state_d, state_q;
  logic [STEP_W-1:0] remain_d, remain_q;
  logic              dir_d, dir_q;
  logic              err_d, err_q;
  logic              accept, stall, load_en, step_en;

`ifdef COUNT_CTRL_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  // Ready is masked by rst so nothing can be accepted on a reset edge.
  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    dir_d    = dir_q;
    err_d    = 1'b0;
    load_en  = 1'b0;
    step_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_load) begin
            state_d = ST_DONE;
            if (cmd_value <= DIGIT_MAX) load_en = 1'b1;
            else                        err_d   = 1'b1;
          end else if (cmd_steps == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_RUN;
            remain_d = cmd_steps;
            dir_d    = cmd_dir;
          end
        end
      end
      ST_RUN: begin
        if (!stall) begin
          step_en  = 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == STEP_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      remain_q <= '0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
    end
  end

  mod10_digit u_digit (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .load_val (cmd_value),
    .step_en  (step_en),
    .step_up  (dir_q),
    .digit    (digit),
    .wrap     (wrap)
  );

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_mod10_count_ctrl.sv
// Self-checking bench for mod10_count_ctrl: directed scenarios plus random commands
// checked cycle by cycle against a modulo-arithmetic reference model.
module tb_mod10_count_ctrl;

  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst;
`ifdef COUNT_CTRL_PAUSE_EN
  logic              pause;
`endif
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_load;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic [3:0]        cmd_value;
  logic [3:0]        digit;
  logic              busy, wrap, done, err;

  int n_vec   = 0;
  int n_err   = 0;
  int m_digit = 0;
  int n_wraps = 0;
  int n_dones = 0;

  always #5 clk = ~clk;

  mod10_count_ctrl #(.STEP_W(STEP_W)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef COUNT_CTRL_PAUSE_EN
    .pause     (pause),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .cmd_value (cmd_value),
    .digit     (digit),
    .busy      (busy),
    .wrap      (wrap),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Digit after k single steps from d0, by plain modulo arithmetic.
  function automatic int exp_digit(input int d0, input bit up, input int k);
    if (up) return (d0 + k) % 10;
    else    return (((d0 - k) % 10) + 10) % 10;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, cmd_ready, 1);
    check({tag, "_busy"},  busy,      0);
    check({tag, "_done"},  done,      0);
    check({tag, "_err"},   err,       0);
    check({tag, "_wrap"},  wrap,      0);
    check({tag, "_digit"}, digit,     m_digit);
  endtask

  // Issue one command and follow it until the controller is idle again.
  // With hold set, cmd_valid stays high (with a load of 3) for the whole command.
  task automatic run_cmd(input bit ld, input bit up, input int steps, input int value, input bit hold);
    int d0;
    int e;
    @(negedge clk);
    check("pre_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_dir   = up;
    cmd_steps = steps[STEP_W-1:0];
    cmd_value = value[3:0];
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    else begin
      cmd_load  = 1'b1;
      cmd_value = 4'd3;
    end
    d0 = m_digit;
    if (ld || steps == 0) begin
      if (ld && value <= 9) m_digit = value;
      check("imm_digit", digit, m_digit);
      check("imm_done",  done,  1);
      check("imm_err",   err,   (ld && value > 9) ? 1 : 0);
      check("imm_wrap",  wrap,  0);
      check("imm_busy",  busy,  1);
      check("imm_ready", cmd_ready, 0);
      if (done) n_dones++;
    end else begin
      check("run0_digit", digit, d0);
      check("run0_done",  done,  0);
      check("run0_busy",  busy,  1);
      check("run0_ready", cmd_ready, 0);
      for (int k = 1; k <= steps; k++) begin
        @(negedge clk);
        e = exp_digit(d0, up, k);
        check("run_digit", digit, e);
        check("run_wrap",  wrap,  (up ? (e == 0) : (e == 9)) ? 1 : 0);
        check("run_done",  done,  (k == steps) ? 1 : 0);
        check("run_busy",  busy,  1);
        check("run_ready", cmd_ready, 0);
        if (wrap) n_wraps++;
        if (done) n_dones++;
      end
      m_digit = exp_digit(d0, up, steps);
    end
    @(negedge clk);
    check_idle("post");
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_dir   = 1'b0;
    cmd_steps = '0;
    cmd_value = '0;
`ifdef COUNT_CTRL_PAUSE_EN
    pause     = 1'b0;
`endif

    // Reset held for two edges, then released.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_digit", digit, 0);
    check("rst_done",  done,  0);
    check("rst_wrap",  wrap,  0);
    check("rst_err",   err,   0);
    check("rst_ready", cmd_ready, 0);
    check("rst_busy",  busy,  0);
    rst = 1'b0;
    #1;
    check("rel_ready", cmd_ready, 1);
    m_digit = 0;

    // Up 12 from 0: one wrap, final digit 2.
    n_wraps = 0;
    run_cmd(1'b0, 1'b1, 12, 0, 1'b0);
    check("up12_final", digit, 2);
    check("up12_wraps", n_wraps, 1);

    // Load 7 then down 9: one wrap to 9, final digit 8, two done pulses.
    n_wraps = 0;
    n_dones = 0;
    run_cmd(1'b1, 1'b0, 0, 7, 1'b0);
    run_cmd(1'b0, 1'b0, 9, 0, 1'b0);
    check("dn9_final", digit, 8);
    check("dn9_wraps", n_wraps, 1);
    check("dn9_dones", n_dones, 2);

    // Illegal load, zero-step count, and valid held through a run.
    run_cmd(1'b1, 1'b1, 0, 12, 1'b0);
    check("ld12_digit", digit, 8);
    run_cmd(1'b0, 1'b1, 0, 0, 1'b0);
    check("n0_digit", digit, 8);
    run_cmd(1'b0, 1'b1, 4, 0, 1'b1);
    check("hold_digit", digit, 2);

    // Reset on the third step edge of up 10 from 0.
    run_cmd(1'b1, 1'b1, 0, 0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_load  = 1'b0;
    cmd_dir   = 1'b1;
    cmd_steps = STEP_W'(10);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mr_d0", digit, 0);
    @(negedge clk);
    check("mr_d1", digit, 1);
    @(negedge clk);
    check("mr_d2", digit, 2);
    rst = 1'b1;
    @(negedge clk);
    check("mr_digit", digit, 0);
    check("mr_done",  done,  0);
    check("mr_busy",  busy,  0);
    check("mr_ready", cmd_ready, 0);
    rst = 1'b0;
    m_digit = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mr_nodone", done, 0);
    end
    run_cmd(1'b0, 1'b1, 3, 0, 1'b0);

`ifdef COUNT_CTRL_PAUSE_EN
    // Up 5 from 0 with pause high for three RUN edges: done lands 3 cycles late.
    run_cmd(1'b1, 1'b1, 0, 0, 1'b0);
    begin
      int exp_d[8] = '{1, 2, 2, 2, 2, 3, 4, 5};
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_load  = 1'b0;
      cmd_dir   = 1'b1;
      cmd_steps = STEP_W'(5);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("pz_d0", digit, 0);
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        check("pz_digit", digit, exp_d[k-1]);
        check("pz_done",  done,  (k == 8) ? 1 : 0);
        check("pz_wrap",  wrap,  0);
        if (k == 2) pause = 1'b1;
        if (k == 5) pause = 1'b0;
      end
      m_digit = 5;
      @(negedge clk);
      check_idle("pz_post");
    end
`endif

    // Random commands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      bit ld;
      bit up;
      bit hold;
      int steps;
      int value;
      ld    = $urandom_range(0, 2) == 0;
      up    = $urandom_range(0, 1) == 1;
      hold  = $urandom_range(0, 3) == 0;
      steps = $urandom_range(0, 15);
      value = $urandom_range(0, 15);
      run_cmd(ld, up, steps, value, hold);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
